// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The loader streams a host program into imem and then releases the core.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
  localparam int IMEM_INST_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    RUN  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: loads a program from a valid/ready
// stream at address 0, pads the tail with NOPs, then releases core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_LINE_IMEM = IMEM_ADDR_W,
  parameter int INST_W         = IMEM_INST_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_LINE_IMEM:0]   prog_len,
  input  logic                      in_valid,
  input  logic [INST_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      opr_finished,
  output logic                      imem_we,
  output logic [ADDR_LINE_IMEM-1:0] imem_addr,
  output logic [INST_W-1:0]         imem_wdata,
  output logic                      core_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CNT_W = ADDR_LINE_IMEM + 1;

  // Counter is one bit wider than the address so DEPTH itself is representable.
  localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_LINE_IMEM{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_C  = {1'b0, {ADDR_LINE_IMEM{1'b1}}};
  localparam logic [CNT_W-1:0] ONE_C   = {{ADDR_LINE_IMEM{1'b0}}, 1'b1};
  localparam logic [INST_W-1:0] NOP_W  = INST_W'(NOP_INST);

  loader_state_t               state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            len_q, len_d;
  logic                        we_q, we_d;
  logic [ADDR_LINE_IMEM-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]           wdata_q, wdata_d;
  logic                        core_rst_q, core_rst_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        hs;

  // Valid/ready: a word transfers in any cycle where in_valid && in_ready;
  // in_ready is a pure state decode so the host sees it without a flop delay.
  assign in_ready = (state_q == LOAD);
  assign hs       = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((prog_len != '0) && (prog_len <= DEPTH_C)) begin
            len_d   = prog_len;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_LINE_IMEM-1:0];
          wdata_d = in_data;
          cnt_d   = cnt_q + ONE_C;
          if (cnt_q == (len_q - ONE_C)) begin
            state_d = (len_q < DEPTH_C) ? PAD : RUN;
          end
        end
      end

      PAD: begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_LINE_IMEM-1:0];
        wdata_d = NOP_W;
        cnt_d   = cnt_q + ONE_C;
        if (cnt_q == LAST_C) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (opr_finished) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == LOAD) || (state_d == PAD);
    // Release only once RUN has been held for a cycle, so the core leaves
    // reset the cycle after the last write lands, and re-enters it with done.
    core_rst_d = !((state_q == RUN) && (state_d == RUN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader at DEPTH=8: load, pad, run, reject and reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW    = 3;
  localparam int IW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   prog_len;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          opr_finished;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected write stream as {addr, data}, in order.
  logic [AW+IW-1:0] exp_q[$];

  logic [IW-1:0] words[DEPTH];
  int            gaps[DEPTH];

  imem_loader #(.ADDR_LINE_IMEM(AW), .INST_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_len     (prog_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .opr_finished (opr_finished),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write seen by memory must match the next expected one.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("stray_we", 64'(imem_we), 64'd0);
      else check("wr_word", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   64'(in_ready),   64'd0);
    check({tag, "_we"},    64'(imem_we),    64'd0);
    check({tag, "_addr"},  64'(imem_addr),  64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_crst"},  64'(core_rst),   64'd1);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
    check({tag, "_err"},   64'(err),        64'd0);
  endtask

  task automatic do_start(input logic [AW:0] len);
    start    = 1'b1;
    prog_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] w, input int addr, input int n_gap,
                           input bit disturb);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    for (int g = 0; g < n_gap; g++) begin
      in_valid     = 1'b0;
      in_data      = $urandom;
      start        = disturb;
      prog_len     = 4'd5;
      opr_finished = disturb;
      tick();
      start        = 1'b0;
      opr_finished = 1'b0;
      check("gap_we",   64'(imem_we),  64'd0);
      check("gap_rdy",  64'(in_ready), 64'd1);
      check("gap_err",  64'(err),      64'd0);
      check("gap_done", 64'(done),     64'd0);
    end
    check("hs_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = w;
    exp_q.push_back({a, w});
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check("hs_we", 64'(imem_we), 64'd1);
  endtask

  // NOP fill from 'from' to DEPTH-1, then core reset release one cycle later.
  task automatic expect_tail(input int from);
    logic [AW-1:0] a;
    for (int i = from; i < DEPTH; i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, NOP_INST});
    end
    for (int i = from; i < DEPTH; i++) begin
      tick();
      check("pad_we",  64'(imem_we),  64'd1);
      check("pad_rdy", 64'(in_ready), 64'd0);
    end
    check("last_wr_crst", 64'(core_rst), 64'd1);
    tick();
    check("run_crst", 64'(core_rst), 64'd0);
    check("run_we",   64'(imem_we),  64'd0);
    check("run_busy", 64'(busy),     64'd0);
    check("run_rdy",  64'(in_ready), 64'd0);
  endtask

  task automatic load(input int len, input bit disturb);
    do_start(len[AW:0]);
    check("ld_rdy",  64'(in_ready), 64'd1);
    check("ld_busy", 64'(busy),     64'd1);
    check("ld_crst", 64'(core_rst), 64'd1);
    for (int i = 0; i < len; i++) send_word(words[i], i, gaps[i], disturb);
    check("ld_end_rdy", 64'(in_ready), 64'd0);
    expect_tail(len);
  endtask

  task automatic finish_run();
    tick();
    check("run_hold_crst", 64'(core_rst), 64'd0);
    opr_finished = 1'b1;
    tick();
    opr_finished = 1'b0;
    check("fin_done", 64'(done),     64'd1);
    check("fin_crst", 64'(core_rst), 64'd1);
    tick();
    check("fin_done_low", 64'(done),     64'd0);
    check("fin_crst_idl", 64'(core_rst), 64'd1);
    check("fin_rdy",      64'(in_ready), 64'd0);
  endtask

  task automatic reject(input logic [AW:0] len);
    do_start(len);
    check("rej_err",  64'(err),      64'd1);
    check("rej_rdy",  64'(in_ready), 64'd0);
    check("rej_busy", 64'(busy),     64'd0);
    check("rej_crst", 64'(core_rst), 64'd1);
    tick();
    check("rej_err_low", 64'(err),      64'd0);
    check("rej_rdy2",    64'(in_ready), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b1;
    prog_len     = 4'd3;
    in_valid     = 1'b0;
    in_data      = '0;
    opr_finished = 1'b0;
    for (int i = 0; i < DEPTH; i++) gaps[i] = 0;

    // Reset wins over a simultaneous start.
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rst_nostart_rdy", 64'(in_ready), 64'd0);

    // Basic load with padding.
    words[0] = 32'h2001_0005;
    words[1] = 32'h2002_0007;
    words[2] = 32'h0022_1820;
    load(3, 1'b0);
    finish_run();

    // Full depth: no padding.
    for (int i = 0; i < DEPTH; i++) words[i] = 32'hA5A5_0000 + 32'(i * 17);
    load(DEPTH, 1'b0);
    finish_run();

    // Bubbled input 1,0,0,1,1 with start/opr_finished pulsed during the gaps.
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    gaps[1]  = 2;
    load(3, 1'b1);
    gaps[1]  = 0;
    finish_run();

    // Rejected starts; opr_finished in IDLE is ignored too.
    reject(4'd0);
    reject(4'd9);
    opr_finished = 1'b1;
    tick();
    opr_finished = 1'b0;
    check("idle_fin_done", 64'(done), 64'd0);

    // Reset after the second handshake of a 5-word load.
    for (int i = 0; i < 5; i++) words[i] = 32'hC0DE_0000 + 32'(i);
    do_start(4'd5);
    send_word(words[0], 0, 0, 1'b0);
    send_word(words[1], 1, 0, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    check_reset_vals("mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_we",  64'(imem_we),  64'd0);
      check("post_rst_rdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // Fresh load must start again at address 0.
    words[0] = 32'h0BAD_F00D;
    words[1] = 32'h1234_5678;
    words[2] = 32'h8765_4321;
    load(3, 1'b0);
    finish_run();

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a program from the testbench/host over a valid/ready stream and writes it word-by-word into instruction memory from address 0.
- Pads the unused tail of the memory with NOPs, then releases the core from reset.
- Returns to idle when the core reports `opr_finished`.

Parameters:
- ADDR_LINE_IMEM, 8, instruction-memory address width in words; DEPTH = 2**ADDR_LINE_IMEM.
- INST_W, 32, instruction word width.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- prog_len  input  ADDR_LINE_IMEM+1  number of program words, sampled with start.
- in_valid  input  1  host word valid.
- in_data  input  INST_W  host instruction word.
- in_ready  output  1  loader accepts a word this cycle.
- opr_finished  input  1  core signals program completion.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_LINE_IMEM  instruction-memory word address.
- imem_wdata  output  INST_W  instruction-memory write data.
- core_rst  output  1  holds the pipeline in reset while high.
- busy  output  1  high in LOAD and PAD.
- done  output  1  one-cycle pulse on return from RUN to IDLE.
- err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered except in_ready, which decodes directly from state.
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, busy 0, done 0, err 0. State goes to IDLE, the word counter clears, and any load in progress is abandoned with no further writes.
- States: IDLE, LOAD, PAD, RUN.
- IDLE:
  - core_rst=1, in_ready=0.
  - start with 1 <= prog_len <= DEPTH: latch prog_len, counter=0, go to LOAD.
  - start with prog_len==0 or prog_len>DEPTH: err=1 for the next cycle, stay in IDLE.
- LOAD:
  - in_ready=1, busy=1.
  - A handshake (in_valid && in_ready) in cycle N produces imem_we=1, imem_addr=counter, imem_wdata=in_data in cycle N+1. The counter increments.
  - No handshake means imem_we=0 next cycle; in_data is ignored when in_valid is low.
  - On the handshake of word prog_len-1, in_ready drops the following cycle.
  - If prog_len<DEPTH go to PAD, else go to RUN.
- PAD:
  - in_ready=0.
  - Writes NOP_INST to addresses prog_len..DEPTH-1, one per cycle, back-to-back.
  - Goes to RUN after the write to DEPTH-1 is issued.
- RUN:
  - core_rst=0 from the first RUN cycle, which is the cycle after the final imem_we.
  - in_ready=0, imem_we=0.
  - opr_finished in RUN: go to IDLE, done=1 for one cycle, core_rst=1 from that same cycle.
- Ignored inputs: start outside IDLE; opr_finished outside RUN.
- Counter and widths:
  - The counter is ADDR_LINE_IMEM+1 bits, so the comparison against DEPTH must not wrap.
  - imem_addr is the low ADDR_LINE_IMEM bits of the counter.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package: IMEM_DEPTH, NOP_INST (32'h0000_0000), and the `loader_state_t` enum {IDLE, LOAD, PAD, RUN}.
- No sub-module is needed. Counter, FSM and output registers live in one module. The top level instantiates it alongside the instruction memory that inst_f reads.

Test Plan:
- Basic load (ADDR_LINE_IMEM=3, DEPTH=8):
  - Stimulus: start, prog_len=3, words 0x20010005, 0x20020007, 0x00221820 streamed back-to-back.
  - Required: writes at addresses 0,1,2 one cycle after each handshake, then NOP writes at 3..7 in consecutive cycles, then core_rst=0 one cycle after the addr-7 write.
- Full-depth load:
  - Stimulus: prog_len=8 with 8 words.
  - Required: no PAD writes; RUN is entered the cycle after the addr-7 write.
- Bubbled input:
  - Stimulus: in_valid toggled 1,0,0,1,1 with prog_len=3.
  - Required: imem_we only after the three handshakes, addresses still 0,1,2, and data matches the order of in_data.
- Rejected starts:
  - Stimulus: start with prog_len=0, then start with prog_len=9.
  - Required: err pulses once for each; no imem_we; state stays IDLE; core_rst stays 1.
- Completion and ignored inputs:
  - Stimulus: start during LOAD; opr_finished during LOAD; then opr_finished in RUN.
  - Required: start and opr_finished during LOAD have no effect; opr_finished in RUN gives done=1 for exactly one cycle and core_rst back to 1 in that cycle.
- Reset mid-operation:
  - Stimulus: reset asserted after the second handshake of a 5-word load.
  - Required: all outputs return to reset values next cycle, no further imem_we, and a fresh start reloads from address 0.
